// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB traffic always wins, long-latency results
// queue in a small FIFO and drain on idle WB cycles, with WAW kill and starvation request.
module rf_wport_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [37:0] ws_to_rf_bus,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_dest,
  input  logic [31:0] lu_data,
  output logic [37:0] rf_bus,
  output logic        rf_src,
  output logic [31:0] pend_mask,
  output logic        starve_req
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  logic [4:0]      dest_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_cnt_q, starve_cnt_d;
  logic            starve_req_q;

  logic       wb_we;
  logic [4:0] wb_addr;
  logic       kill, push, pop, push_live;

  assign wb_we     = ws_to_rf_bus[37];
  assign wb_addr   = ws_to_rf_bus[36:32];
  assign kill      = wb_we && (wb_addr != 5'd0);
  assign lu_ready  = (count_q < CntW'(DEPTH));
  assign pop       = !wb_we && (count_q != '0);
  // Dest 0 completes the handshake but is never stored.
  assign push      = lu_valid && lu_ready && (lu_dest != 5'd0);
  // Queued results are older than WB, so a same-cycle WB write to the same reg wins.
  assign push_live = !(kill && (lu_dest == wb_addr));
  assign rf_src     = pop;
  assign starve_req = starve_req_q;

  always_comb begin
    rf_bus = ws_to_rf_bus;
    if (pop) rf_bus = {live_q[rd_ptr_q], dest_q[rd_ptr_q], data_q[rd_ptr_q]};
  end

  always_comb begin
    live_d = live_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (kill && (dest_q[i] == wb_addr)) live_d[i] = 1'b0;
    end
    if (pop)  live_d[rd_ptr_q] = 1'b0;
    if (push) live_d[wr_ptr_q] = push_live;
  end

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pend_mask[dest_q[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop) begin
      starve_cnt_d = '0;
    end else if ((count_q != '0) && wb_we && (starve_cnt_q != StW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + StW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      starve_req_q <= 1'b0;
    end else begin
      live_q       <= live_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      starve_req_q <= (starve_cnt_d == StW'(STARVE_MAX));
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Payload storage needs no reset; validity lives in live_q and count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr_q] <= lu_dest;
      data_q[wr_ptr_q] <= lu_data;
    end
  end

endmodule
